// File: rtl/spi_pkg.sv
// Shared definitions for the SPI memory transaction controller:
// default byte/address widths, the R/W encoding and the FSM state type.
package spi_pkg;

  localparam int   SPI_WIDTH   = 8;
  localparam int   SPI_ADDR_W  = SPI_WIDTH - 1;
  localparam logic SPI_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_GET_ADDR     = 3'd1,
    ST_GOT_ADDR     = 3'd2,
    ST_READ_LOAD    = 3'd3,
    ST_READ_SHIFT   = 3'd4,
    ST_WRITE_SHIFT  = 3'd5,
    ST_WRITE_COMMIT = 3'd6,
    ST_DONE         = 3'd7
  } spi_state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating SCLK pulse counter shared by the address and data phases.
// last_o flags the pulse that completes a byte; done_o flags a full count.
module spi_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o,
  output logic done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority, increment stops at WIDTH.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CNT_LAST);
  assign done_o = (count_q == CNT_MAX);

endmodule

// File: rtl/spi_control_fsm.sv
// SPI memory transaction controller: address byte, R/W bit, then data byte(s).
// Define SPI_ADDR_AUTOINC_EN for burst mode (address auto-increment per data byte).
module spi_control_fsm
  import spi_pkg::*;
#(
  parameter int WIDTH  = SPI_WIDTH,
  parameter int ADDR_W = SPI_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              sclk_pos_edge,
  input  logic [WIDTH-1:0]  sr_pout,
  output logic              sr_load,
  output logic [ADDR_W-1:0] addr_out,
  output logic              dm_we,
  output logic              miso_buf_en,
  output logic              busy
);

  spi_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sr_load_q, dm_we_q, miso_buf_en_q, busy_q;
  logic              cnt_clr_s, cnt_inc_s, cnt_last_s, cnt_done_s;
  logic              phase_end_s;
`ifdef SPI_ADDR_AUTOINC_EN
  logic              rw_q, rw_d;
`endif

  spi_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr_s),
    .inc_i  (cnt_inc_s),
    .last_o (cnt_last_s),
    .done_o (cnt_done_s)
  );

  // A phase ends on the pulse that completes the byte, not one clk later.
  assign phase_end_s = (sclk_pos_edge && cnt_last_s) || cnt_done_s;

  // Next-state, address latch and counter control.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
    rw_d      = rw_q;
`endif
    if (cs_n) begin
      state_d   = ST_IDLE;
      cnt_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_GET_ADDR;
          cnt_clr_s = 1'b1;
        end
        ST_GET_ADDR: begin
          cnt_inc_s = sclk_pos_edge;
          if (phase_end_s) begin
            state_d   = ST_GOT_ADDR;
            cnt_clr_s = 1'b1;
          end else begin
            state_d   = ST_GET_ADDR;
          end
        end
        ST_GOT_ADDR: begin
          addr_d    = sr_pout[WIDTH-1:1];
`ifdef SPI_ADDR_AUTOINC_EN
          rw_d      = sr_pout[0];
`endif
          cnt_clr_s = 1'b1;
          state_d   = (sr_pout[0] == SPI_RW_READ) ? ST_READ_LOAD : ST_WRITE_SHIFT;
        end
        ST_READ_LOAD: begin
          state_d   = ST_READ_SHIFT;
          cnt_clr_s = 1'b1;
        end
        ST_READ_SHIFT: begin
          cnt_inc_s = sclk_pos_edge;
          if (phase_end_s) begin
            state_d   = ST_DONE;
            cnt_clr_s = 1'b1;
          end else begin
            state_d   = ST_READ_SHIFT;
          end
        end
        ST_WRITE_SHIFT: begin
          cnt_inc_s = sclk_pos_edge;
          if (phase_end_s) begin
            state_d   = ST_WRITE_COMMIT;
            cnt_clr_s = 1'b1;
          end else begin
            state_d   = ST_WRITE_SHIFT;
          end
        end
        ST_WRITE_COMMIT: begin
          state_d   = ST_DONE;
          cnt_clr_s = 1'b1;
        end
        ST_DONE: begin
          cnt_clr_s = 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
          // Burst: DONE is a single step that advances to the next address.
          addr_d    = addr_q + ADDR_W'(1);
          state_d   = (rw_q == SPI_RW_READ) ? ST_READ_LOAD : ST_WRITE_SHIFT;
`else
          state_d   = ST_DONE;
`endif
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State, address and Moore outputs decoded from the next state so they align with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= {ADDR_W{1'b0}};
      sr_load_q     <= 1'b0;
      dm_we_q       <= 1'b0;
      miso_buf_en_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      sr_load_q     <= (state_d == ST_READ_LOAD);
      dm_we_q       <= (state_d == ST_WRITE_COMMIT);
      miso_buf_en_q <= (state_d == ST_READ_SHIFT);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

`ifdef SPI_ADDR_AUTOINC_EN
  // Transfer direction held for the rest of the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q <= 1'b0;
    end else begin
      rw_q <= rw_d;
    end
  end
`endif

  assign sr_load     = sr_load_q;
  assign addr_out    = addr_q;
  assign dm_we       = dm_we_q;
  assign miso_buf_en = miso_buf_en_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_control_fsm.sv
// Randomized scoreboard bench for spi_control_fsm; the reference model predicts
// memory-side events per frame from pulse counts and honours SPI_ADDR_AUTOINC_EN.
module tb_spi_control_fsm;

`ifdef SPI_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct {
    bit         rd;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       sclk_pos_edge;
  logic       mosi;
  logic [7:0] sr_q;
  logic       sr_load;
  logic [6:0] addr_out;
  logic       dm_we;
  logic       miso_buf_en;
  logic       busy;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  miso_cnt = 0;

  spi_control_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .cs_n          (cs_n),
    .sclk_pos_edge (sclk_pos_edge),
    .sr_pout       (sr_q),
    .sr_load       (sr_load),
    .addr_out      (addr_out),
    .dm_we         (dm_we),
    .miso_buf_en   (miso_buf_en),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Shift register beside the controller: shifts MOSI in MSB first, loads memory data on sr_load.
  always @(posedge clk or posedge reset) begin
    if (reset) sr_q <= 8'h00;
    else if (sclk_pos_edge) sr_q <= {sr_q[6:0], mosi};
    else if (sr_load) sr_q <= {1'b0, addr_out} ^ 8'h3C;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitor: every memory-side event pops the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (sclk_pos_edge && miso_buf_en) miso_cnt++;
      if (dm_we || sr_load) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, dm_we, sr_load}, 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("event_kind", {31'd0, sr_load}, {31'd0, e.rd});
          chk("event_addr", {25'd0, addr_out}, {25'd0, e.addr});
          if (!e.rd) chk("write_data", {24'd0, sr_q}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic pulse(input logic b, input bit raise_cs);
    @(posedge clk); #2;
    sclk_pos_edge = 1'b1;
    mosi          = b;
    if (raise_cs) cs_n = 1'b1;
    @(posedge clk); #2;
    sclk_pos_edge = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // One chip-select frame: address byte, nbytes full data bytes, extra partial pulses.
  // sim=1 raises cs_n in the same cycle as the final pulse, so that pulse does not count.
  task automatic frame(input logic [6:0] a, input bit rw, input logic [7:0] d0,
                       input int nbytes, input int extra, input bit sim);
    logic [7:0] abyte;
    logic [7:0] dbytes[4];
    int p, peff, nev, miso_exp;
    ev_t e;
    abyte = {a, rw};
    for (int k = 0; k < 4; k++) dbytes[k] = 8'($urandom);
    dbytes[0] = d0;
    p    = 8 + 8 * nbytes + extra;
    peff = sim ? p - 1 : p;
    if (rw) begin
      nev      = AUTOINC ? (peff - 8) / 8 + 1 : 1;
      miso_exp = AUTOINC ? peff - 8 : ((peff - 8) > 8 ? 8 : peff - 8);
    end else begin
      nev      = (peff - 8) / 8;
      if (!AUTOINC && nev > 1) nev = 1;
      miso_exp = 0;
    end
    for (int k = 0; k < nev; k++) begin
      e.rd   = rw;
      e.addr = 7'((int'(a) + k) % 128);
      e.data = dbytes[k];
      exp_q.push_back(e);
    end
    miso_cnt = 0;
    @(posedge clk); #2;
    cs_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < p; i++) begin
      if (i < 8) pulse(abyte[7 - i], 1'b0);
      else       pulse(dbytes[(i - 8) / 8][7 - ((i - 8) % 8)], sim && (i == p - 1));
    end
    #2 cs_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_cs", {31'd0, busy}, 32'd0);
    chk("dm_we_after_cs", {31'd0, dm_we}, 32'd0);
    chk("miso_pulses", miso_cnt, miso_exp);
    chk("events_pending", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Write frame interrupted by async reset after 4 data pulses.
  task automatic reset_mid_write();
    logic [7:0] abyte;
    abyte = {7'h15, 1'b0};
    @(posedge clk); #2;
    cs_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) pulse(abyte[7 - i], 1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
    #2;
    chk("busy_before_reset", {31'd0, busy}, 32'd1);
    chk("addr_before_reset", {25'd0, addr_out}, 32'h15);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {21'd0, sr_load, dm_we, miso_buf_en, busy, addr_out},
        32'd0);
    repeat (2) @(posedge clk); #2;
    cs_n  = 1'b1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle_after_reset", {30'd0, busy, dm_we}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    cs_n          = 1'b1;
    sclk_pos_edge = 1'b0;
    mosi          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {21'd0, sr_load, dm_we, miso_buf_en, busy, addr_out}, 32'd0);
    reset = 1'b0;

    frame(7'h2A, 1'b0, 8'hA5, 1, 0, 1'b0);
    chk("write_addr_latched", {25'd0, addr_out}, 32'h2A);
    frame(7'h2A, 1'b1, 8'h00, 1, 0, 1'b0);
    frame(7'h33, 1'b0, 8'h5A, 0, 5, 1'b0);
    frame(7'h41, 1'b0, 8'hC3, 1, 0, 1'b1);
    reset_mid_write();
    frame(7'h7F, 1'b0, 8'h81, 2, 0, 1'b0);
    frame(7'h7E, 1'b1, 8'h00, 3, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [6:0] a;
      bit rw;
      int nb, ex;
      bit sim;
      a   = 7'($urandom_range(0, 127));
      rw  = 1'($urandom_range(0, 1));
      nb  = $urandom_range(0, 3);
      ex  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      sim = !rw && (nb > 0) && (ex == 0) && ($urandom_range(0, 2) == 0);
      frame(a, rw, 8'($urandom), nb, ex, sim);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
